tlul_host_arbiter: RTL and testbench
====================================

Name: tlul_host_arbiter

Overview:
- Two-to-one TL-UL host arbiter that merges the core's instruction-fetch and data host ports onto a single TL-UL host port toward the crossbar or a single-ported memory.
- Sits between the core wrapper's two tlul_host_adapter instances and the downstream device.
- Arbitrates the A channel round-robin with a hold lock, and tags a_source with the host index.
- Routes D-channel responses back by tag and limits outstanding requests per host.

Parameters:
- MaxOutstanding, 2, maximum in-flight A requests per host (1..15); matches the adapters' MAX_REQS.
- DataPriority, 1'b1, on reset and on ties the data host wins the first arbitration.

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-low reset
- tl_h0_i  input  tlul_pkg::tl_h2d_t  host 0 (instruction) request
- tl_h0_o  output  tlul_pkg::tl_d2h_t  host 0 response
- tl_h1_i  input  tlul_pkg::tl_h2d_t  host 1 (data) request
- tl_h1_o  output  tlul_pkg::tl_d2h_t  host 1 response
- tl_d_o  output  tlul_pkg::tl_h2d_t  merged request to device
- tl_d_i  input  tlul_pkg::tl_d2h_t  device response
- busy_o  output  1  any outstanding request or locked grant
- err_src_o  output  1  one-cycle pulse on a D beat whose tag host has zero outstanding

Behaviour:
- Reset values (asynchronous, reset==0):
  - all a_valid/d_valid/a_ready outputs are 0; busy_o=0; err_src_o=0.
  - lock=0; rr_ptr selects host 1 if DataPriority, else host 0; both outstanding counters are 0.
- Eligibility: host n is eligible when tl_hn_i.a_valid=1 and outstanding[n] < MaxOutstanding.
- Arbiter states:
  - IDLE (lock=0): combinational grant to an eligible host.
    - Only one eligible host: that host wins.
    - Both eligible: the host indicated by rr_ptr wins.
    - tl_d_o.a_valid = winner's a_valid, in the same cycle as the host's request (zero-latency pass-through).
  - Still in IDLE, if the device does not assert a_ready that cycle: lock=1 and sel=winner, move to HOLD.
  - HOLD (lock=1): keep presenting sel regardless of the other host, preserving TL-UL A-channel stability.
    - Leave HOLD on a_valid && a_ready.
    - If the locked host drops a_valid (a protocol violation), release the lock the next cycle; no assertion is raised in RTL.
- On accept (tl_d_o.a_valid && tl_d_i.a_ready):
  - rr_ptr = the other host; outstanding[sel] increments.
- Outbound tag: tl_d_o.a_source = {sel, host a_source[6:0]}. Hosts must keep a_source[7]=0; bit 7 is overwritten.
- All other A fields pass through unmodified from the selected host.
- a_ready to the losing or ineligible host is 0.
- D routing:
  - tag t = tl_d_i.d_source[7]; tl_ht_o.d_valid = tl_d_i.d_valid.
  - d_source returned with bit 7 cleared; the other host sees d_valid=0.
  - tl_d_o.d_ready = tl_ht_i.d_ready.
- On a D beat (d_valid && d_ready): outstanding[t] decrements.
- Same-cycle accept and response for the same host: the counter is unchanged (+1-1).
- Counter guards:
  - Decrement when outstanding[t]==0: saturate at 0 and pulse err_src_o.
  - An increment is never possible at MaxOutstanding (eligibility gate).
- Counter width is $clog2(MaxOutstanding+1).
- a_ready to a host is combinationally dependent on the device's a_ready; d_ready toward the device depends combinationally on the host's d_ready. No registers are in either data path.
- busy_o = lock | (outstanding[0]!=0) | (outstanding[1]!=0), registered-free combinational.
- Reset asserted mid-transaction:
  - Counters and lock clear immediately.
  - In-flight responses arriving after reset release raise err_src_o and are still forwarded by tag.

Decomposition:
- tlul_pkg already supplies tl_h2d_t/tl_d2h_t and TL_AIW=8.
- Add to tlul_pkg: localparam ArbTagBit = TL_AIW-1; typedef enum logic {ArbIdle, ArbHold} arb_state_e.
- One natural sub-module, tlul_outstanding_ctr (inc, dec, count, full, underflow_err), instantiated once per host.

Test Plan:
- Single host: h1 issues Get at 0x0000_1000 with source 0x03, device a_ready=1 -> device sees a_source=0x83 in the same cycle; D response source 0x83 returns to h1 as 0x03; outstanding[1] goes 0->1->0.
- Contention: h0 and h1 both request every cycle with device always ready -> grants alternate h1,h0,h1,h0 from reset (DataPriority=1); no starvation over 100 cycles.
- Backpressure hold: h0 wins, device a_ready=0 for 5 cycles while h1 also requests -> tl_d_o stays h0's request, h1 a_ready=0 throughout; after accept, h1 is granted next.
- Outstanding limit: MaxOutstanding=2, h0 issues 3 Gets with no D response -> third not forwarded, h0 a_ready=0; after one D beat tagged h0, third is accepted the next cycle.
- Simultaneous accept and response on h1 with outstanding=1 -> count stays 1; spurious D with source 0x05 while outstanding[0]=0 -> err_src_o pulses 1 cycle, count stays 0.
- Reset with 2 outstanding on h1 -> busy_o=0 immediately; post-reset arbitration starts at h1.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the core-side hosts and the arbiter.
// Also holds the tag bit position and the arbiter state encoding.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // MSB of a_source carries the originating host index downstream.
  localparam int ArbTagBit = TL_AIW - 1;

  typedef enum logic {
    ArbIdle,
    ArbHold
  } arb_state_e;

endpackage

// File: rtl/tlul_outstanding_ctr.sv
// Per-host count of A requests accepted downstream but not yet answered.
// A decrement at zero saturates and reports a stray response instead.
module tlul_outstanding_ctr #(
  parameter int MaxOutstanding = 2,
  parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            underflow_err
);

  logic [CntW-1:0] count_q, count_d;
  logic            dec_ok;

  always_comb begin
    dec_ok        = dec && (count_q != '0);
    underflow_err = dec && (count_q == '0);
    count_d       = count_q;
    if (inc && !dec_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!inc && dec_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q >= CntW'(MaxOutstanding));

endmodule

// File: rtl/tlul_host_arbiter.sv
// Two-to-one TL-UL host arbiter: round-robin A-channel grant with a hold lock,
// host index tagged into a_source MSB, D responses routed back by that tag.
module tlul_host_arbiter
  import tlul_pkg::*;
#(
  parameter int   MaxOutstanding = 2,
  parameter logic DataPriority   = 1'b1
) (
  input  logic    clock,
  input  logic    reset,
  input  tl_h2d_t tl_h0_i,
  output tl_d2h_t tl_h0_o,
  input  tl_h2d_t tl_h1_i,
  output tl_d2h_t tl_h1_o,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    busy_o,
  output logic    err_src_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  arb_state_e      state_q, state_d;
  logic            sel_q, sel_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            win, gnt_valid, accept;
  logic            tag, dev_d_ready, d_beat;
  logic [1:0]      req_valid, elig, full, inc, dec, underflow;
  logic [CntW-1:0] count_h0, count_h1;

  assign req_valid = {tl_h1_i.a_valid, tl_h0_i.a_valid};
  assign elig      = req_valid & ~full;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    win       = sel_q;
    gnt_valid = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        win       = (elig[0] && elig[1]) ? rr_ptr_q : elig[1];
        gnt_valid = elig[0] | elig[1];
        if (gnt_valid && !tl_d_i.a_ready) begin
          state_d = ArbHold;
          sel_d   = win;
        end
      end
      ArbHold: begin
        // A locked host that drops a_valid simply releases the lock.
        win       = sel_q;
        gnt_valid = req_valid[sel_q];
        if (!gnt_valid || tl_d_i.a_ready) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  assign accept   = gnt_valid && tl_d_i.a_ready;
  assign rr_ptr_d = accept ? ~win : rr_ptr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ArbIdle;
      sel_q    <= 1'b0;
      rr_ptr_q <= DataPriority;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign tag         = tl_d_i.d_source[ArbTagBit];
  assign dev_d_ready = tag ? tl_h1_i.d_ready : tl_h0_i.d_ready;
  assign d_beat      = tl_d_i.d_valid && dev_d_ready;

  always_comb begin
    tl_d_o                     = win ? tl_h1_i : tl_h0_i;
    tl_d_o.a_valid             = gnt_valid;
    tl_d_o.a_source[ArbTagBit] = win;
    tl_d_o.d_ready             = dev_d_ready;
  end

  always_comb begin
    tl_h0_o                     = tl_d_i;
    tl_h0_o.d_source[ArbTagBit] = 1'b0;
    tl_h0_o.d_valid             = tl_d_i.d_valid && !tag;
    tl_h0_o.a_ready             = accept && !win;
    tl_h1_o                     = tl_d_i;
    tl_h1_o.d_source[ArbTagBit] = 1'b0;
    tl_h1_o.d_valid             = tl_d_i.d_valid && tag;
    tl_h1_o.a_ready             = accept && win;
  end

  assign inc = {accept && win, accept && !win};
  assign dec = {d_beat && tag, d_beat && !tag};

  tlul_outstanding_ctr #(
    .MaxOutstanding(MaxOutstanding),
    .CntW          (CntW)
  ) u_ctr_h0 (
    .clock        (clock),
    .reset        (reset),
    .inc          (inc[0]),
    .dec          (dec[0]),
    .count        (count_h0),
    .full         (full[0]),
    .underflow_err(underflow[0])
  );

  tlul_outstanding_ctr #(
    .MaxOutstanding(MaxOutstanding),
    .CntW          (CntW)
  ) u_ctr_h1 (
    .clock        (clock),
    .reset        (reset),
    .inc          (inc[1]),
    .dec          (dec[1]),
    .count        (count_h1),
    .full         (full[1]),
    .underflow_err(underflow[1])
  );

  assign err_src_o = |underflow;
  assign busy_o    = (state_q == ArbHold) || (count_h0 != '0) || (count_h1 != '0);

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter: stimulus pushes expected A/D beats into
// queues, a negedge monitor pops and compares whenever a beat is handshaked.
module tb_tlul_host_arbiter;
  import tlul_pkg::*;

  logic    clock = 1'b0;
  logic    reset = 1'b0;
  tl_h2d_t h0_req, h1_req, dev_req;
  tl_d2h_t h0_rsp, h1_rsp, dev_rsp;
  logic    busy, err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0]  src;
    logic [31:0] word;
  } beat_t;

  beat_t exp_a[$];
  beat_t exp_d0[$];
  beat_t exp_d1[$];

  always #5 clock = ~clock;

  tlul_host_arbiter #(
    .MaxOutstanding(2),
    .DataPriority  (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .tl_h0_i  (h0_req),
    .tl_h0_o  (h0_rsp),
    .tl_h1_i  (h1_req),
    .tl_h1_o  (h1_rsp),
    .tl_d_o   (dev_req),
    .tl_d_i   (dev_rsp),
    .busy_o   (busy),
    .err_src_o(err)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [39:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got beat 0x%0h, expected no beat", name, act);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset) begin
      if (dev_req.a_valid && dev_rsp.a_ready) begin
        if (exp_a.size() == 0) unexpected("a_beat", {dev_req.a_source, dev_req.a_address});
        else check("a_beat", {dev_req.a_source, dev_req.a_address}, exp_a.pop_front());
      end
      if (h0_rsp.d_valid && h0_req.d_ready) begin
        if (exp_d0.size() == 0) unexpected("d_beat_h0", {h0_rsp.d_source, h0_rsp.d_data});
        else check("d_beat_h0", {h0_rsp.d_source, h0_rsp.d_data}, exp_d0.pop_front());
      end
      if (h1_rsp.d_valid && h1_req.d_ready) begin
        if (exp_d1.size() == 0) unexpected("d_beat_h1", {h1_rsp.d_source, h1_rsp.d_data});
        else check("d_beat_h1", {h1_rsp.d_source, h1_rsp.d_data}, exp_d1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input int h, input logic v, input logic [7:0] src, input logic [31:0] addr);
    tl_h2d_t r;
    r = (h == 1) ? h1_req : h0_req;
    r.a_valid   = v;
    r.a_opcode  = Get;
    r.a_param   = 3'd0;
    r.a_size    = 2'd2;
    r.a_source  = src;
    r.a_address = addr;
    r.a_mask    = 4'hf;
    r.a_data    = 32'h0;
    r.d_ready   = 1'b1;
    if (h == 1) h1_req = r;
    else h0_req = r;
  endtask

  task automatic dev_d(input logic v, input logic [7:0] src, input logic [31:0] data);
    dev_rsp.d_valid  = v;
    dev_rsp.d_opcode = AccessAckData;
    dev_rsp.d_source = src;
    dev_rsp.d_data   = data;
  endtask

  initial begin
    logic [31:0] addr0, addr1;
    logic        prev_win, win;

    h0_req = '0;
    h1_req = '0;
    h0_req.d_ready = 1'b1;
    h1_req.d_ready = 1'b1;
    dev_rsp = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_dev_a_valid", dev_req.a_valid, 0);
    check("rst_h0_a_ready", h0_rsp.a_ready, 0);
    check("rst_h1_a_ready", h1_rsp.a_ready, 0);
    check("rst_h0_d_valid", h0_rsp.d_valid, 0);
    check("rst_h1_d_valid", h1_rsp.d_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    step();
    reset = 1'b1;

    // Single host: tag insertion and removal
    dev_rsp.a_ready = 1'b1;
    req(1, 1, 8'h03, 32'h0000_1000);
    exp_a.push_back({8'h83, 32'h0000_1000});
    @(negedge clock);
    check("t1_h1_a_ready", h1_rsp.a_ready, 1);
    check("t1_dev_src", dev_req.a_source, 8'h83);
    step();
    req(1, 0, 8'h03, 32'h0000_1000);
    check("t1_cnt_up", dut.u_ctr_h1.count, 1);
    dev_d(1, 8'h83, 32'hCAFE_0001);
    exp_d1.push_back({8'h03, 32'hCAFE_0001});
    @(negedge clock);
    check("t1_h0_no_d", h0_rsp.d_valid, 0);
    step();
    dev_d(0, 8'h00, 32'h0);
    check("t1_cnt_down", dut.u_ctr_h1.count, 0);
    check("t1_busy", busy, 0);

    reset = 1'b0;
    step();
    reset = 1'b1;

    // Contention: alternating grants from h1, each answered the next cycle
    addr0 = 32'h2000;
    addr1 = 32'h3000;
    prev_win = 1'b0;
    for (int i = 0; i < 100; i++) begin
      win = (i % 2 == 0);
      req(0, 1, 8'h11, addr0);
      req(1, 1, 8'h22, addr1);
      if (win) exp_a.push_back({8'hA2, addr1});
      else exp_a.push_back({8'h11, addr0});
      if (i > 0) begin
        dev_d(1, prev_win ? 8'hA2 : 8'h11, 32'(i));
        if (prev_win) exp_d1.push_back({8'h22, 32'(i)});
        else exp_d0.push_back({8'h11, 32'(i)});
      end
      step();
      if (win) addr1 += 32'd4;
      else addr0 += 32'd4;
      prev_win = win;
    end
    req(0, 0, 8'h11, addr0);
    req(1, 0, 8'h22, addr1);
    dev_d(1, 8'h11, 32'd100);
    exp_d0.push_back({8'h11, 32'd100});
    step();
    dev_d(0, 8'h00, 32'h0);
    check("t2_cnt0", dut.u_ctr_h0.count, 0);
    check("t2_cnt1", dut.u_ctr_h1.count, 0);

    // Backpressure: h0 locked for 5 cycles while h1 waits
    dev_rsp.a_ready = 1'b0;
    req(0, 1, 8'h31, 32'h4000);
    exp_a.push_back({8'h31, 32'h4000});
    @(negedge clock);
    check("t3_first_src", dev_req.a_source, 8'h31);
    step();
    for (int k = 0; k < 4; k++) begin
      req(1, 1, 8'h32, 32'h5000);
      @(negedge clock);
      check("t3_hold_src", dev_req.a_source, 8'h31);
      check("t3_hold_addr", dev_req.a_address, 32'h4000);
      check("t3_h1_blocked", h1_rsp.a_ready, 0);
      check("t3_busy", busy, 1);
      step();
    end
    dev_rsp.a_ready = 1'b1;
    @(negedge clock);
    check("t3_h0_accept", h0_rsp.a_ready, 1);
    step();
    req(0, 1, 8'h31, 32'h4004);
    exp_a.push_back({8'hB2, 32'h5000});
    @(negedge clock);
    check("t3_h1_next", h1_rsp.a_ready, 1);
    check("t3_h0_waits", h0_rsp.a_ready, 0);
    step();
    req(1, 0, 8'h32, 32'h5000);
    exp_a.push_back({8'h31, 32'h4004});
    step();
    req(0, 0, 8'h31, 32'h4004);
    dev_d(1, 8'h31, 32'h1);
    exp_d0.push_back({8'h31, 32'h1});
    step();
    dev_d(1, 8'hB2, 32'h2);
    exp_d1.push_back({8'h32, 32'h2});
    step();
    dev_d(1, 8'h31, 32'h3);
    exp_d0.push_back({8'h31, 32'h3});
    step();
    dev_d(0, 8'h00, 32'h0);
    check("t3_busy_end", busy, 0);

    // Outstanding limit on h0
    req(0, 1, 8'h41, 32'h6000);
    exp_a.push_back({8'h41, 32'h6000});
    step();
    req(0, 1, 8'h41, 32'h6004);
    exp_a.push_back({8'h41, 32'h6004});
    step();
    req(0, 1, 8'h41, 32'h6008);
    @(negedge clock);
    check("t4_blocked_valid", dev_req.a_valid, 0);
    check("t4_blocked_ready", h0_rsp.a_ready, 0);
    step();
    dev_d(1, 8'h41, 32'hD1);
    exp_d0.push_back({8'h41, 32'hD1});
    @(negedge clock);
    check("t4_still_blocked", dev_req.a_valid, 0);
    step();
    dev_d(0, 8'h00, 32'h0);
    exp_a.push_back({8'h41, 32'h6008});
    @(negedge clock);
    check("t4_third_accept", h0_rsp.a_ready, 1);
    step();
    req(0, 0, 8'h41, 32'h6008);
    dev_d(1, 8'h41, 32'hD2);
    exp_d0.push_back({8'h41, 32'hD2});
    step();
    dev_d(1, 8'h41, 32'hD3);
    exp_d0.push_back({8'h41, 32'hD3});
    step();
    dev_d(0, 8'h00, 32'h0);
    check("t4_cnt0", dut.u_ctr_h0.count, 0);

    // Same-cycle accept and response on h1, then a stray response for h0
    req(1, 1, 8'h51, 32'h7000);
    exp_a.push_back({8'hD1, 32'h7000});
    step();
    req(1, 1, 8'h51, 32'h7004);
    exp_a.push_back({8'hD1, 32'h7004});
    dev_d(1, 8'hD1, 32'hE1);
    exp_d1.push_back({8'h51, 32'hE1});
    step();
    req(1, 0, 8'h51, 32'h7004);
    dev_d(0, 8'h00, 32'h0);
    check("t5_cnt1_same", dut.u_ctr_h1.count, 1);
    dev_d(1, 8'hD1, 32'hE2);
    exp_d1.push_back({8'h51, 32'hE2});
    step();
    dev_d(1, 8'h05, 32'hBAD);
    exp_d0.push_back({8'h05, 32'hBAD});
    check("t5_cnt1_zero", dut.u_ctr_h1.count, 0);
    @(negedge clock);
    check("t5_err_pulse", err, 1);
    step();
    dev_d(0, 8'h00, 32'h0);
    @(negedge clock);
    check("t5_err_clear", err, 0);
    check("t5_cnt0", dut.u_ctr_h0.count, 0);
    step();

    // Reset with two h1 requests in flight
    req(1, 1, 8'h61, 32'h8000);
    exp_a.push_back({8'hE1, 32'h8000});
    step();
    req(1, 1, 8'h61, 32'h8004);
    exp_a.push_back({8'hE1, 32'h8004});
    step();
    req(1, 0, 8'h61, 32'h8004);
    check("t6_cnt1", dut.u_ctr_h1.count, 2);
    check("t6_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("t6_busy_reset", busy, 0);
    check("t6_cnt1_reset", dut.u_ctr_h1.count, 0);
    step();
    reset = 1'b1;
    req(0, 1, 8'h62, 32'h9000);
    req(1, 1, 8'h61, 32'h8008);
    exp_a.push_back({8'hE1, 32'h8008});
    dev_d(1, 8'hE1, 32'hF1);
    exp_d1.push_back({8'h61, 32'hF1});
    @(negedge clock);
    check("t6_first_h1", h1_rsp.a_ready, 1);
    check("t6_late_err", err, 1);
    step();
    req(1, 0, 8'h61, 32'h8008);
    dev_d(0, 8'h00, 32'h0);
    exp_a.push_back({8'h62, 32'h9000});
    step();
    req(0, 0, 8'h62, 32'h9000);
    dev_d(1, 8'hE1, 32'hF2);
    exp_d1.push_back({8'h61, 32'hF2});
    step();
    dev_d(1, 8'h62, 32'hF3);
    exp_d0.push_back({8'h62, 32'hF3});
    step();
    dev_d(0, 8'h00, 32'h0);
    @(negedge clock);
    check("t6_busy_end", busy, 0);

    check("end_exp_a_empty", exp_a.size(), 0);
    check("end_exp_d0_empty", exp_d0.size(), 0);
    check("end_exp_d1_empty", exp_d1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
